// File: rtl/ic1_boot_loader_if.sv
// ic1_boot_loader_if
//   Bundles the two buses of the boot loader: the inbound 8-bit valid/ready
//   byte stream and the outbound single-cycle program-memory write port.
//
//   Signals
//     in_valid                 byte-stream valid (from link bridge)
//     in_data[7:0]             byte-stream data
//     in_ready                 byte-stream ready (from loader)
//     ic1_c_axi_mst_wr_valid   one-cycle write strobe to program memory
//     ic1_axi_mst_wr_addr      byte write address
//     ic1_axi_mst_wr_data      write data
//
//   Modports
//     master  the loader: consumes the byte stream, drives the write port
//     slave   the environment: link bridge plus program memory
interface ic1_boot_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        ic1_c_axi_mst_wr_valid;
    logic [31:0] ic1_axi_mst_wr_addr;
    logic [31:0] ic1_axi_mst_wr_data;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output ic1_c_axi_mst_wr_valid,
        output ic1_axi_mst_wr_addr,
        output ic1_axi_mst_wr_data
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  ic1_c_axi_mst_wr_valid,
        input  ic1_axi_mst_wr_addr,
        input  ic1_axi_mst_wr_data
    );
endinterface

// File: rtl/ic1_boot_loader.sv
// ic1_boot_loader
//   Byte-serial program loader. Parses a frame
//     MAGIC | base[4 bytes LE] | N[2 bytes LE] | N words (LE bytes) | checksum
//   from the byte stream, writes each assembled word to program memory with a
//   one-cycle strobe at base + 4*i, and releases the core reset only after the
//   checksum (mod-256 sum of the data bytes) matches.
//
//   Ports
//     clk         system clock
//     c_sys_rst   synchronous active-high reset
//     bus         ic1_boot_loader_if.master (byte stream in, write port out)
//     c_core_rst  core reset, high unless a verified image is loaded
//     load_done   image loaded and verified
//     load_err    frame error, sticky until the next MAGIC or reset
module ic1_boot_loader #(
    parameter int         MAX_WORDS = 4096,
    parameter logic [7:0] MAGIC     = 8'hA5
) (
    input  logic                  clk,
    input  logic                  c_sys_rst,
    ic1_boot_loader_if.master     bus,
    output logic                  c_core_rst,
    output logic                  load_done,
    output logic                  load_err
);

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        SYNC     = 3'd0,
        HDR_ADDR = 3'd1,
        HDR_CNT  = 3'd2,
        DATA     = 3'd3,
        CHK      = 3'd4,
        DONE     = 3'd5,
        ERR      = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  byte_cnt;
    logic [31:0] base_addr;
    logic [15:0] word_cnt;
    logic [15:0] word_idx;
    logic [23:0] word_acc;   // low three bytes of the word being assembled
    logic [7:0]  csum;

    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    logic        accept;
    logic        is_magic;
    logic [31:0] addr_shift;
    logic [15:0] cnt_shift;
    logic [31:0] word_full;
    logic        last_word;

    logic        wr_fire;
    logic        done_nxt;
    logic        err_nxt;
    logic        core_rst_nxt;

    // The stream is never back-pressured: memory has no stall and every
    // state consumes one byte per cycle.
    assign bus.in_ready = 1'b1;

    assign accept     = bus.in_valid & bus.in_ready;
    assign is_magic   = (bus.in_data == MAGIC);
    // Header fields and data words all arrive LSB first, so each new byte is
    // shifted in at the top.
    assign addr_shift = {bus.in_data, base_addr[31:8]};
    assign cnt_shift  = {bus.in_data, word_cnt[15:8]};
    assign word_full  = {bus.in_data, word_acc};
    assign last_word  = (word_idx == (word_cnt - 16'd1));

    assign bus.ic1_c_axi_mst_wr_valid = wr_valid;
    assign bus.ic1_axi_mst_wr_addr    = wr_addr;
    assign bus.ic1_axi_mst_wr_data    = wr_data;

    // State register.
    always_ff @(posedge clk) begin
        if (c_sys_rst) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; MAGIC is only recognised in SYNC, DONE and ERR.
    always_comb begin
        state_nxt = state;
        case (state)
            SYNC, DONE, ERR: begin
                if (accept && is_magic) begin
                    state_nxt = HDR_ADDR;
                end else begin
                    state_nxt = state;
                end
            end
            HDR_ADDR: begin
                if (accept && (byte_cnt == 2'd3)) begin
                    if (addr_shift[1:0] != 2'b00) begin
                        state_nxt = ERR;
                    end else begin
                        state_nxt = HDR_CNT;
                    end
                end else begin
                    state_nxt = HDR_ADDR;
                end
            end
            HDR_CNT: begin
                if (accept && (byte_cnt == 2'd1)) begin
                    if ({1'b0, cnt_shift} > MAX_W) begin
                        state_nxt = ERR;
                    end else if (cnt_shift == 16'd0) begin
                        state_nxt = CHK;
                    end else begin
                        state_nxt = DATA;
                    end
                end else begin
                    state_nxt = HDR_CNT;
                end
            end
            DATA: begin
                if (accept && (byte_cnt == 2'd3) && last_word) begin
                    state_nxt = CHK;
                end else begin
                    state_nxt = DATA;
                end
            end
            CHK: begin
                if (accept) begin
                    if (bus.in_data == csum) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ERR;
                    end
                end else begin
                    state_nxt = CHK;
                end
            end
            default: begin
                state_nxt = SYNC;
            end
        endcase
    end

    // Output decode: values the registered outputs take on the next edge.
    always_comb begin
        wr_fire      = (state == DATA) && accept && (byte_cnt == 2'd3);
        done_nxt     = (state_nxt == DONE);
        err_nxt      = (state_nxt == ERR);
        core_rst_nxt = (state_nxt != DONE);
    end

    // Datapath, write port and status registers.
    always_ff @(posedge clk) begin
        if (c_sys_rst) begin
            byte_cnt   <= 2'd0;
            base_addr  <= 32'd0;
            word_cnt   <= 16'd0;
            word_idx   <= 16'd0;
            word_acc   <= 24'd0;
            csum       <= 8'd0;
            wr_valid   <= 1'b0;
            wr_addr    <= 32'd0;
            wr_data    <= 32'd0;
            c_core_rst <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            wr_valid   <= wr_fire;
            c_core_rst <= core_rst_nxt;
            load_done  <= done_nxt;
            load_err   <= err_nxt;
            if (wr_fire) begin
                // 32-bit wrap-around of base + 4*i is intentional.
                wr_addr <= base_addr + {14'd0, word_idx, 2'b00};
                wr_data <= word_full;
            end else begin
                wr_addr <= wr_addr;
                wr_data <= wr_data;
            end
            if (accept) begin
                case (state)
                    SYNC, DONE, ERR: begin
                        if (is_magic) begin
                            byte_cnt <= 2'd0;
                            csum     <= 8'd0;
                            word_idx <= 16'd0;
                        end else begin
                            byte_cnt <= byte_cnt;
                        end
                    end
                    HDR_ADDR: begin
                        base_addr <= addr_shift;
                        byte_cnt  <= byte_cnt + 2'd1;
                    end
                    HDR_CNT: begin
                        word_cnt <= cnt_shift;
                        word_idx <= 16'd0;
                        if (byte_cnt == 2'd1) begin
                            byte_cnt <= 2'd0;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                    DATA: begin
                        word_acc <= word_full[31:8];
                        csum     <= csum + bus.in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            word_idx <= word_idx + 16'd1;
                        end else begin
                            word_idx <= word_idx;
                        end
                    end
                    default: begin
                        byte_cnt <= byte_cnt;
                    end
                endcase
            end else begin
                byte_cnt <= byte_cnt;
            end
        end
    end

endmodule
